// File: rtl/breath_led_pwm.sv
// Breathing-LED PWM generator clocked by sys_clk and advanced by one-cycle tick_in enables.
// Define LED_ACTIVE_LOW_EN to invert led_out for active-low board LEDs.
module breath_led_pwm #(
   parameter int PWM_STEPS    = 64,
   parameter int HOLD_PERIODS = 2,
   parameter int DUTY_W       = $clog2(PWM_STEPS + 1)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              tick_in,
   input  logic              enable,
   output logic              led_out,
   output logic              period_done,
   output logic [DUTY_W-1:0] duty_level
);

   localparam int CNT_W  = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
   localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

   localparam logic [CNT_W-1:0]  PWM_LAST  = CNT_W'(PWM_STEPS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PWM_STEPS);

`ifdef LED_ACTIVE_LOW_EN
   localparam logic LED_OFF = 1'b1;
`else
   localparam logic LED_OFF = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RISE = 2'd1,
      FALL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic                period_done_q, period_done_d;
   logic                led_q, led_d;

   always_comb begin
      state_d       = state_q;
      pwm_cnt_d     = pwm_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      duty_d        = duty_q;
      period_done_d = 1'b0;
      // Compare uses the registered count/duty, so led_out lags them by one edge.
      led_d = LED_OFF ^ ((state_q != IDLE) && (DUTY_W'(pwm_cnt_q) < duty_q));

      if (!enable) begin
         state_d    = IDLE;
         pwm_cnt_d  = '0;
         hold_cnt_d = '0;
         duty_d     = '0;
      end else if (state_q == IDLE) begin
         state_d    = RISE;
         pwm_cnt_d  = '0;
         hold_cnt_d = '0;
         duty_d     = '0;
      end else if (tick_in) begin
         if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d     = '0;
            period_done_d = 1'b1;
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               if (state_q == RISE) begin
                  duty_d = duty_q + DUTY_W'(1);
                  if (duty_d == DUTY_MAX) state_d = FALL;
               end else begin
                  duty_d = duty_q - DUTY_W'(1);
                  if (duty_d == '0) state_d = RISE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end else begin
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= IDLE;
         pwm_cnt_q     <= '0;
         hold_cnt_q    <= '0;
         duty_q        <= '0;
         period_done_q <= 1'b0;
         led_q         <= LED_OFF;
      end else begin
         state_q       <= state_d;
         pwm_cnt_q     <= pwm_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         duty_q        <= duty_d;
         period_done_q <= period_done_d;
         led_q         <= led_d;
      end
   end

   assign led_out     = led_q;
   assign period_done = period_done_q;
   assign duty_level  = duty_q;

endmodule

// File: tb/tb_breath_led_pwm.sv
// Directed bench for breath_led_pwm with PWM_STEPS=4, HOLD_PERIODS=1 and a one-in-six tick.
// Each period end pops an expected {gap, state, led-high count, duty} record from exp_q.
module tb_breath_led_pwm;

   localparam int STEPS    = 4;
   localparam int HOLD     = 1;
   localparam int DW       = 3;
   localparam int TICK_DIV = 6;
   localparam int PER      = STEPS * TICK_DIV;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RISE = 2'd1;
   localparam logic [1:0] S_FALL = 2'd2;

`ifdef LED_ACTIVE_LOW_EN
   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;
`else
   localparam logic LED_ON  = 1'b1;
   localparam logic LED_OFF = 1'b0;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic          tick_in;
   logic          enable;
   logic          led_out;
   logic          period_done;
   logic [DW-1:0] duty_level;

   always #5 sys_clk = ~sys_clk;

   breath_led_pwm #(
      .PWM_STEPS    (STEPS),
      .HOLD_PERIODS (HOLD)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .tick_in     (tick_in),
      .enable      (enable),
      .led_out     (led_out),
      .period_done (period_done),
      .duty_level  (duty_level)
   );

   logic [31:0]   exp_q[$];
   int            n_tests;
   int            n_fail;
   int            k;
   int            since_pd;
   int            led_cnt;
   int            pd_seen;
   int            pd_base;
   logic          tick_force;
   logic [DW-1:0] prev_duty;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_period(input int gap, input logic [1:0] st, input int leds, input int duty);
      exp_q.push_back({8'(gap), 6'd0, st, 8'(leds), 8'(duty)});
   endtask

   task automatic cyc();
      logic [31:0] e;
      tick_in = tick_force || (k % TICK_DIV == 0);
      @(posedge sys_clk);
      #1;
      k++;
      since_pd++;
      if (led_out === LED_ON) led_cnt++;
      if (enable === 1'b1 && sys_rst === 1'b0)
         check("duty_only_at_period_end",
               {31'd0, (period_done === 1'b1) || (duty_level === prev_duty)}, 32'd1);
      if (period_done === 1'b1) begin
         pd_seen++;
         check("period_done_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("period_gap", 32'(since_pd), {24'd0, e[31:24]});
            check("state_at_period_end", 32'(dut.state_q), {30'd0, e[17:16]});
            check("led_high_clocks", 32'(led_cnt), {24'd0, e[15:8]});
            check("duty_after_step", 32'(duty_level), {24'd0, e[7:0]});
         end
         since_pd = 0;
         led_cnt  = 0;
      end
      prev_duty = duty_level;
   endtask

   task automatic run_to(input int n);
      while (k < n) cyc();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_led"}, {31'd0, led_out}, {31'd0, LED_OFF});
      check({tag, "_period_done"}, {31'd0, period_done}, 32'd0);
      check({tag, "_duty"}, 32'(duty_level), 32'd0);
      check({tag, "_state"}, 32'(dut.state_q), 32'(S_IDLE));
      check({tag, "_pwm_cnt"}, 32'(dut.pwm_cnt_q), 32'd0);
      check({tag, "_hold_cnt"}, 32'(dut.hold_cnt_q), 32'd0);
   endtask

   task automatic restart();
      k        = 0;
      since_pd = -1;
      led_cnt  = 0;
   endtask

   initial begin
      logic [1:0] st_seq [9];
      int         duty_seq [10];
      n_tests    = 0;
      n_fail     = 0;
      k          = 1;
      since_pd   = 0;
      led_cnt    = 0;
      pd_seen    = 0;
      tick_force = 1'b0;
      prev_duty  = '0;
      sys_rst    = 1'b1;
      enable     = 1'b0;
      tick_in    = 1'b0;
      st_seq     = '{S_RISE, S_RISE, S_RISE, S_FALL, S_FALL, S_FALL, S_FALL, S_RISE, S_RISE};
      duty_seq   = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

      // Reset, then idle with enable low.
      cyc();
      cyc();
      check_reset_values("reset");
      sys_rst = 1'b0;
      cyc();
      check("idle_hold_state", 32'(dut.state_q), 32'(S_IDLE));
      check("idle_hold_led", {31'd0, led_out}, {31'd0, LED_OFF});

      // Full breath cycle plus one step; the tick at the enable edge is ignored.
      for (int i = 1; i < 10; i++)
         expect_period(PER, st_seq[i-1], duty_seq[i-1] * TICK_DIV, duty_seq[i]);
      enable = 1'b1;
      restart();
      run_to(1);
      check("enter_rise_state", 32'(dut.state_q), 32'(S_RISE));
      check("enter_rise_pwm", 32'(dut.pwm_cnt_q), 32'd0);
      run_to(7);
      check("first_tick_pwm", 32'(dut.pwm_cnt_q), 32'd1);
      run_to(26);
      check("duty1_led_on", {31'd0, led_out}, {31'd0, LED_ON});
      check("duty1_level", 32'(duty_level), 32'd1);
      run_to(32);
      check("duty1_led_off", {31'd0, led_out}, {31'd0, LED_OFF});
      run_to(9 * PER + 1);
      check("breath_cycle_consumed", 32'(exp_q.size()), 32'd0);

      // Disable on the period-end tick: enable wins.
      run_to(10 * PER);
      enable = 1'b0;
      cyc();
      check("disable_state", 32'(dut.state_q), 32'(S_IDLE));
      check("disable_duty", 32'(duty_level), 32'd0);
      check("disable_period_done", {31'd0, period_done}, 32'd0);
      check("disable_pwm", 32'(dut.pwm_cnt_q), 32'd0);
      cyc();
      check("disable_led", {31'd0, led_out}, {31'd0, LED_OFF});

      // Reset while at duty 3 in FALL, with enable still high.
      for (int i = 1; i < 6; i++)
         expect_period(PER, st_seq[i-1], duty_seq[i-1] * TICK_DIV, duty_seq[i]);
      enable = 1'b1;
      restart();
      run_to(130);
      check("pre_reset_state", 32'(dut.state_q), 32'(S_FALL));
      check("pre_reset_duty", 32'(duty_level), 32'd3);
      check("pre_reset_led", {31'd0, led_out}, {31'd0, LED_ON});
      sys_rst = 1'b1;
      cyc();
      check_reset_values("mid_reset");
      sys_rst = 1'b0;
      expect_period(PER, S_RISE, 0, 1);
      restart();
      run_to(1);
      check("restart_state", 32'(dut.state_q), 32'(S_RISE));
      check("restart_duty", 32'(duty_level), 32'd0);
      run_to(PER + 1);
      check("restart_consumed", 32'(exp_q.size()), 32'd0);

      // Tick held high for four clocks wraps pwm_cnt exactly once.
      expect_period(4, S_RISE, 1, 2);
      pd_base    = pd_seen;
      tick_force = 1'b1;
      run_to(PER + 5);
      tick_force = 1'b0;
      check("tick_high_wrap_pwm", 32'(dut.pwm_cnt_q), 32'd0);
      check("tick_high_pd_now", {31'd0, period_done}, 32'd1);
      run_to(PER + 7);
      check("tick_high_pd_once", 32'(pd_seen - pd_base), 32'd1);
      check("tick_high_consumed", 32'(exp_q.size()), 32'd0);
      check("tick_high_duty", 32'(duty_level), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
